// File: rtl/spdif_i2s_sample_capture.sv
// Oversampling I2S receiver behind the S/PDIF decoder: synchronizes bck/ws/d0 on clk_in,
// deserializes MSB-first words and emits one left/right PCM pair per frame with lock and error tracking.
module spdif_i2s_sample_capture #(
    parameter int DATA_W      = 24,
    parameter int MIN_BITS    = 16,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk_in,
    input  logic              resetb,
    input  logic              i2s_bck,
    input  logic              i2s_ws,
    input  logic              i2s_d0,
    input  logic              audio_locked,
    output logic [DATA_W-1:0] sample_l,
    output logic [DATA_W-1:0] sample_r,
    output logic              sample_valid,
    output logic              locked,
    output logic [7:0]        err_cnt
);
    localparam int                 TMO_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0]   TMO_MAX = TMO_W'(TIMEOUT_CYC);
    localparam logic [6:0]         MIN_LEN = 7'(MIN_BITS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2
    } state_t;

    logic [2:0]        bck_sync_r, ws_sync_r, d0_sync_r;
    logic              bck_rise_s;
    logic              rise_r, ws_smp_r, d0_smp_r;
    logic [DATA_W-1:0] shreg_r, shreg_wr_s, word_r, hold_l_r, hold_l_nxt_s;
    logic [5:0]        bit_cnt_r;
    logic [6:0]        word_len_s, word_len_r;
    logic              ws_last_r, boundary_s, bnd_r, bnd_ws_r;
    logic [TMO_W-1:0]  tmo_cnt_r;
    logic              timeout_s, short_s;
    state_t            state_r, state_nxt_s;
    logic              valid_nxt_s, locked_nxt_s, err_inc_s, load_s;

    assign bck_rise_s = bck_sync_r[1] & ~bck_sync_r[2];
    assign boundary_s = rise_r & (ws_smp_r != ws_last_r);
    assign word_len_s = {1'b0, bit_cnt_r} + 7'd1;
    assign timeout_s  = (tmo_cnt_r == TMO_MAX) & ~bck_rise_s;
    assign short_s    = (word_len_r < MIN_LEN);

    // Three-flop synchronizers; index 1 is s2, index 2 is s3.
    always_ff @(posedge clk_in or negedge resetb) begin
        if (!resetb) begin
            bck_sync_r <= 3'b000;
            ws_sync_r  <= 3'b000;
            d0_sync_r  <= 3'b000;
        end else begin
            bck_sync_r <= {bck_sync_r[1:0], i2s_bck};
            ws_sync_r  <= {ws_sync_r[1:0], i2s_ws};
            d0_sync_r  <= {d0_sync_r[1:0], i2s_d0};
        end
    end

    // Sample ws/d0 on each bit-clock rise; this stage also sets the fixed output latency.
    always_ff @(posedge clk_in or negedge resetb) begin
        if (!resetb) begin
            rise_r   <= 1'b0;
            ws_smp_r <= 1'b0;
            d0_smp_r <= 1'b0;
        end else begin
            rise_r <= bck_rise_s;
            if (bck_rise_s) begin
                ws_smp_r <= ws_sync_r[1];
                d0_smp_r <= d0_sync_r[1];
            end
        end
    end

    // Place the current bit at its MSB-first position; bits past DATA_W match no index.
    always_comb begin
        shreg_wr_s = shreg_r;
        for (int i = 0; i < DATA_W; i++) begin
            if (rise_r && (bit_cnt_r == 6'(DATA_W - 1 - i))) begin
                shreg_wr_s[i] = d0_smp_r;
            end else begin
                shreg_wr_s[i] = shreg_r[i];
            end
        end
    end

    // Deserializer: a ws change closes the word, the bit on that edge being its LSB.
    always_ff @(posedge clk_in or negedge resetb) begin
        if (!resetb) begin
            shreg_r    <= '0;
            bit_cnt_r  <= 6'd0;
            ws_last_r  <= 1'b0;
            bnd_r      <= 1'b0;
            bnd_ws_r   <= 1'b0;
            word_r     <= '0;
            word_len_r <= 7'd0;
        end else begin
            bnd_r <= boundary_s;
            if (rise_r) begin
                ws_last_r <= ws_smp_r;
                if (boundary_s) begin
                    word_r     <= shreg_wr_s;
                    word_len_r <= word_len_s;
                    bnd_ws_r   <= ws_smp_r;
                    shreg_r    <= '0;
                    bit_cnt_r  <= 6'd0;
                end else begin
                    shreg_r   <= shreg_wr_s;
                    bit_cnt_r <= (bit_cnt_r == 6'd63) ? 6'd63 : bit_cnt_r + 6'd1;
                end
            end
        end
    end

    // Bit-clock watchdog, saturating so a stalled link is reported once.
    always_ff @(posedge clk_in or negedge resetb) begin
        if (!resetb) begin
            tmo_cnt_r <= '0;
        end else if (bck_rise_s) begin
            tmo_cnt_r <= '0;
        end else if (tmo_cnt_r != TMO_MAX) begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
        end
    end

    // Frame FSM state register.
    always_ff @(posedge clk_in or negedge resetb) begin
        if (!resetb) begin
            state_r  <= ST_IDLE;
            hold_l_r <= '0;
        end else begin
            state_r  <= state_nxt_s;
            hold_l_r <= hold_l_nxt_s;
        end
    end

    // Frame FSM next state; a timeout outranks a lost decoder lock so only one error is counted.
    always_comb begin
        state_nxt_s  = state_r;
        hold_l_nxt_s = hold_l_r;
        valid_nxt_s  = 1'b0;
        locked_nxt_s = locked;
        err_inc_s    = 1'b0;
        load_s       = 1'b0;
        if ((state_r != ST_IDLE) && timeout_s) begin
            err_inc_s    = 1'b1;
            locked_nxt_s = 1'b0;
            state_nxt_s  = ST_IDLE;
        end else if (!audio_locked) begin
            locked_nxt_s = 1'b0;
            state_nxt_s  = ST_IDLE;
        end else if (bnd_r) begin
            case (state_r)
                ST_IDLE: begin
                    if (!bnd_ws_r) begin
                        state_nxt_s = ST_LEFT;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_LEFT, ST_RIGHT: begin
                    if (short_s) begin
                        err_inc_s    = 1'b1;
                        locked_nxt_s = 1'b0;
                        state_nxt_s  = bnd_ws_r ? ST_IDLE : ST_LEFT;
                    end else if ((state_r == ST_LEFT) && bnd_ws_r) begin
                        hold_l_nxt_s = word_r;
                        state_nxt_s  = ST_RIGHT;
                    end else if ((state_r == ST_RIGHT) && !bnd_ws_r) begin
                        load_s       = 1'b1;
                        valid_nxt_s  = 1'b1;
                        locked_nxt_s = 1'b1;
                        state_nxt_s  = ST_LEFT;
                    end else begin
                        state_nxt_s = state_r;
                    end
                end
                default: begin
                    locked_nxt_s = 1'b0;
                    state_nxt_s  = ST_IDLE;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Registered outputs; samples only change together with the valid pulse.
    always_ff @(posedge clk_in or negedge resetb) begin
        if (!resetb) begin
            sample_l     <= '0;
            sample_r     <= '0;
            sample_valid <= 1'b0;
            locked       <= 1'b0;
            err_cnt      <= 8'd0;
        end else begin
            sample_valid <= valid_nxt_s;
            locked       <= locked_nxt_s;
            if (load_s) begin
                sample_l <= hold_l_r;
                sample_r <= word_r;
            end
            if (err_inc_s && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_spdif_i2s_sample_capture.sv
// Directed bench for spdif_i2s_sample_capture: drives I2S frames with an 8-clock bit period
// and checks samples, pulse count, latency, lock and error counting against hand-computed values.
module tb_spdif_i2s_sample_capture;
    logic        clk_in = 1'b0;
    logic        resetb = 1'b0;
    logic        i2s_bck = 1'b0;
    logic        i2s_ws = 1'b0;
    logic        i2s_d0 = 1'b0;
    logic        audio_locked = 1'b1;
    logic [23:0] sample_l, sample_r;
    logic        sample_valid, locked;
    logic [7:0]  err_cnt;

    int errors = 0;
    int checks = 0;
    int pulses = 0;
    int lat;

    spdif_i2s_sample_capture dut (
        .clk_in(clk_in), .resetb(resetb), .i2s_bck(i2s_bck), .i2s_ws(i2s_ws),
        .i2s_d0(i2s_d0), .audio_locked(audio_locked), .sample_l(sample_l),
        .sample_r(sample_r), .sample_valid(sample_valid), .locked(locked), .err_cnt(err_cnt)
    );

    always #5 clk_in = ~clk_in;

    // Count valid cycles, sampled on the inactive edge.
    always @(negedge clk_in) begin
        if (resetb && sample_valid) pulses = pulses + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic w, input logic d);
        @(negedge clk_in);
        i2s_bck = 1'b0;
        i2s_ws  = w;
        i2s_d0  = d;
        repeat (4) @(negedge clk_in);
        i2s_bck = 1'b1;
        repeat (3) @(negedge clk_in);
    endtask

    // n bits MSB-first; the LSB goes out with the next word's ws (one-bit delay).
    task automatic send_word(input logic w, input logic [31:0] data, input int n,
                             input logic nws, input int drop_at);
        logic [31:0] tmp;
        for (int i = 0; i < n; i++) begin
            if (i == drop_at) begin
                @(negedge clk_in);
                audio_locked = 1'b0;
                @(negedge clk_in);
                audio_locked = 1'b1;
            end
            tmp = data >> (n - 1 - i);
            send_bit((i == n - 1) ? nws : w, tmp[0]);
        end
    endtask

    task automatic frame32(input logic [23:0] l, input logic [23:0] r);
        send_word(1'b0, {l, 8'h00}, 32, 1'b1, -1);
        send_word(1'b1, {r, 8'h00}, 32, 1'b0, -1);
    endtask

    task automatic settle();
        repeat (8) @(negedge clk_in);
    endtask

    initial begin
        logic [31:0] rw;
        // Reset state
        repeat (5) @(negedge clk_in);
        chk("rst_l", 32'(sample_l), 32'h0);
        chk("rst_r", 32'(sample_r), 32'h0);
        chk("rst_valid", 32'(sample_valid), 32'h0);
        chk("rst_locked", 32'(locked), 32'h0);
        chk("rst_err", 32'(err_cnt), 32'h0);
        resetb = 1'b1;

        // 32-bit slots: first frame only synchronizes
        frame32(24'hA5C3F1, 24'h123456);
        settle();
        chk("sync_no_pulse", 32'(pulses), 32'd0);
        frame32(24'hA5C3F1, 24'h123456);
        settle();
        chk("f32_pulse", 32'(pulses), 32'd1);
        chk("f32_l", 32'(sample_l), 32'hA5C3F1);
        chk("f32_r", 32'(sample_r), 32'h123456);
        chk("f32_locked", 32'(locked), 32'h1);

        // Latency from the right word's LSB bck rise
        send_word(1'b0, 32'h5A5A5A00, 32, 1'b1, -1);
        rw = 32'h12345600;
        for (int i = 0; i < 31; i++) send_bit(1'b1, rw[31 - i]);
        @(negedge clk_in);
        i2s_bck = 1'b0; i2s_ws = 1'b0; i2s_d0 = rw[0];
        repeat (4) @(negedge clk_in);
        i2s_bck = 1'b1;
        lat = 0;
        @(posedge clk_in);
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk_in);
            #1;
            if (sample_valid && lat == 0) lat = k;
        end
        chk("latency", 32'(lat), 32'd4);
        settle();
        chk("lat_pulse", 32'(pulses), 32'd2);
        chk("lat_l", 32'(sample_l), 32'h5A5A5A);
        chk("f32_err", 32'(err_cnt), 32'h0);

        // 16-bit slots, zero-padded at the LSB end
        send_word(1'b0, 32'h8001, 16, 1'b1, -1);
        send_word(1'b1, 32'h7FFF, 16, 1'b0, -1);
        settle();
        chk("f16_pulse", 32'(pulses), 32'd3);
        chk("f16_l", 32'(sample_l), 32'h800100);
        chk("f16_r", 32'(sample_r), 32'h7FFF00);

        // Short left word
        send_word(1'b0, 32'h2AA, 10, 1'b1, -1);
        send_word(1'b1, 32'h12345600, 32, 1'b0, -1);
        settle();
        chk("short_err", 32'(err_cnt), 32'd1);
        chk("short_locked", 32'(locked), 32'h0);
        chk("short_no_pulse", 32'(pulses), 32'd3);
        chk("short_keep_l", 32'(sample_l), 32'h800100);
        frame32(24'h0F0F0F, 24'hF0F0F0);
        settle();
        chk("relock_pulse", 32'(pulses), 32'd4);
        chk("relock_l", 32'(sample_l), 32'h0F0F0F);
        chk("relock_r", 32'(sample_r), 32'hF0F0F0);
        chk("relock_locked", 32'(locked), 32'h1);

        // Bit clock stops while locked
        repeat (200) @(negedge clk_in);
        chk("tmo_before_locked", 32'(locked), 32'h1);
        chk("tmo_before_err", 32'(err_cnt), 32'd1);
        repeat (100) @(negedge clk_in);
        chk("tmo_locked", 32'(locked), 32'h0);
        chk("tmo_err", 32'(err_cnt), 32'd2);
        frame32(24'h111111, 24'h222222);
        settle();
        chk("tmo_idle_no_pulse", 32'(pulses), 32'd4);
        frame32(24'h111111, 24'h222222);
        settle();
        chk("tmo_resync_pulse", 32'(pulses), 32'd5);
        chk("tmo_resync_l", 32'(sample_l), 32'h111111);
        chk("tmo_resync_locked", 32'(locked), 32'h1);

        // Decoder lock drops for one cycle mid-right-word
        send_word(1'b0, 32'h33333300, 32, 1'b1, -1);
        send_word(1'b1, 32'h44444400, 32, 1'b0, 10);
        settle();
        chk("alock_no_pulse", 32'(pulses), 32'd5);
        chk("alock_err", 32'(err_cnt), 32'd2);
        chk("alock_locked", 32'(locked), 32'h0);
        frame32(24'h555555, 24'h666666);
        settle();
        chk("alock_relock_pulse", 32'(pulses), 32'd6);
        chk("alock_relock_r", 32'(sample_r), 32'h666666);

        // One error per frame of short words, saturating at 255
        for (int f = 0; f < 100; f++) begin
            send_word(1'b0, 32'hA, 4, 1'b1, -1);
            send_word(1'b1, 32'h5, 4, 1'b0, -1);
        end
        settle();
        chk("sat_err_mid", 32'(err_cnt), 32'd102);
        for (int f = 0; f < 200; f++) begin
            send_word(1'b0, 32'hA, 4, 1'b1, -1);
            send_word(1'b1, 32'h5, 4, 1'b0, -1);
        end
        settle();
        chk("sat_err", 32'(err_cnt), 32'd255);
        chk("sat_locked", 32'(locked), 32'h0);
        chk("sat_no_pulse", 32'(pulses), 32'd6);

        // Reset in the middle of a frame
        frame32(24'h0A0B0C, 24'h0D0E0F);
        settle();
        chk("pre_rst_pulse", 32'(pulses), 32'd7);
        chk("pre_rst_locked", 32'(locked), 32'h1);
        for (int i = 0; i < 10; i++) send_bit(1'b0, 1'b1);
        @(negedge clk_in);
        i2s_bck = 1'b0;
        resetb = 1'b0;
        #1;
        chk("mid_rst_l", 32'(sample_l), 32'h0);
        chk("mid_rst_r", 32'(sample_r), 32'h0);
        chk("mid_rst_locked", 32'(locked), 32'h0);
        chk("mid_rst_err", 32'(err_cnt), 32'h0);
        chk("mid_rst_valid", 32'(sample_valid), 32'h0);
        repeat (3) @(negedge clk_in);
        resetb = 1'b1;
        frame32(24'h777777, 24'h888888);
        settle();
        chk("post_rst_no_pulse", 32'(pulses), 32'd7);
        frame32(24'h777777, 24'h888888);
        settle();
        chk("post_rst_pulse", 32'(pulses), 32'd8);
        chk("post_rst_l", 32'(sample_l), 32'h777777);
        chk("post_rst_r", 32'(sample_r), 32'h888888);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
